// File: rtl/sw_debounce_capture_if.sv
// Switch/key debounce bundle: raw levels and clear strobes in, debounced level,
// edge pulses and sticky rise capture out.
interface sw_debounce_capture_if;
    logic [3:0] RAW;
    logic [3:0] CLR;
    logic [3:0] DOUT;
    logic [3:0] RISE;
    logic [3:0] FALL;
    logic [3:0] EDGE;

    modport master (
        output RAW,
        output CLR,
        input  DOUT,
        input  RISE,
        input  FALL,
        input  EDGE
    );

    modport slave (
        input  RAW,
        input  CLR,
        output DOUT,
        output RISE,
        output FALL,
        output EDGE
    );
endinterface

// File: rtl/sw_debounce_capture.sv
// Four independent switch/key debouncers: two-flop synchroniser, stable-count
// qualification, registered rise/fall pulses and a sticky, clearable rise capture.
module sw_debounce_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    sw_debounce_capture_if.slave  bus
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit              INV      = (ACTIVE_LOW != 0);
    // Released-key level for the synchroniser, so inversion yields 0 out of reset.
    localparam logic [3:0]      SYNC_RST = INV ? 4'b1111 : 4'b0000;

    logic [3:0]       s1_q, s1_d;
    logic [3:0]       s2_q, s2_d;
    logic [3:0]       synced;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       rise_q, rise_d;
    logic [3:0]       fall_q, fall_d;
    logic [3:0]       edge_q, edge_d;

    assign synced = INV ? ~s2_q : s2_q;

    always_comb begin
        s1_d     = bus.RAW;
        s2_d     = s1_q;
        stable_d = stable_q;
        rise_d   = 4'b0000;
        fall_d   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            // A differing sample extends the streak; any matching sample restarts it.
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = synced[i];
                    rise_d[i]   = synced[i];
                    fall_d[i]   = ~synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Set from the previous cycle's RISE takes priority over a concurrent clear.
        edge_d = (edge_q & ~bus.CLR) | rise_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q     <= SYNC_RST;
            s2_q     <= SYNC_RST;
            stable_q <= 4'b0000;
            rise_q   <= 4'b0000;
            fall_q   <= 4'b0000;
            edge_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            edge_q   <= edge_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.DOUT = stable_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
    assign bus.EDGE = edge_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// Bench for sw_debounce_capture: one active-high and one active-low instance
// checked every cycle against a sample-window reference model plus directed checks.
module tb_sw_debounce_capture;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    sw_debounce_capture_if bus_a ();
    sw_debounce_capture_if bus_b ();

    sw_debounce_capture #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (bus_a)
    );

    sw_debounce_capture #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    int rise1_count = 0;

    // Reference model: raw samples delayed two cycles, then a level is accepted
    // once the last D synced samples all disagree with the current output level.
    logic [3:0] m_s1   [2];
    logic [3:0] m_s2   [2];
    logic [3:0] m_dout [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic [3:0] m_edge [2];
    bit         win    [2][4][D];

    task automatic model_reset(input int k);
        m_s1[k]   = (k == 1) ? 4'b1111 : 4'b0000;
        m_s2[k]   = m_s1[k];
        m_dout[k] = 4'b0000;
        m_rise[k] = 4'b0000;
        m_fall[k] = 4'b0000;
        m_edge[k] = 4'b0000;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < D; j++)
                win[k][c][j] = 1'b0;
    endtask

    task automatic model_clock(input int k, input logic [3:0] raw, input logic [3:0] clr);
        logic [3:0] syn;
        logic [3:0] nd, nr, nf;
        bit         all_diff;
        syn = (k == 1) ? ~m_s2[k] : m_s2[k];
        nd = m_dout[k];
        nr = 4'b0000;
        nf = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < D - 1; j++)
                win[k][c][j] = win[k][c][j+1];
            win[k][c][D-1] = syn[c];
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (win[k][c][j] == m_dout[k][c]) all_diff = 1'b0;
            if (all_diff) begin
                nd[c] = syn[c];
                nr[c] = syn[c];
                nf[c] = ~syn[c];
            end
        end
        m_edge[k] = (m_edge[k] & ~clr) | m_rise[k];
        m_dout[k] = nd;
        m_rise[k] = nr;
        m_fall[k] = nf;
        m_s2[k]   = m_s1[k];
        m_s1[k]   = raw;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_dout", bus_a.DOUT, m_dout[0]);
        chk("a_rise", bus_a.RISE, m_rise[0]);
        chk("a_fall", bus_a.FALL, m_fall[0]);
        chk("a_edge", bus_a.EDGE, m_edge[0]);
        chk("b_dout", bus_b.DOUT, m_dout[1]);
        chk("b_rise", bus_b.RISE, m_rise[1]);
        chk("b_fall", bus_b.FALL, m_fall[1]);
        chk("b_edge", bus_b.EDGE, m_edge[1]);
    endtask

    task automatic step(input int n);
        logic [3:0] ra, ca, rb, cb;
        for (int s = 0; s < n; s++) begin
            ra = bus_a.RAW;
            ca = bus_a.CLR;
            rb = bus_b.RAW;
            cb = bus_b.CLR;
            @(posedge clk);
            if (!rst_a) model_clock(0, ra, ca);
            if (!rst_b) model_clock(1, rb, cb);
            #1;
            rise1_count += int'(bus_a.RISE[1]);
            check_all();
        end
    endtask

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        bus_a.RAW = 4'b0000;
        bus_a.CLR = 4'b0000;
        bus_b.RAW = 4'b1111;
        bus_b.CLR = 4'b0000;
        model_reset(0);
        model_reset(1);
        #1;
        check_all();
        step(2);
        chk("reset_dout_a", bus_a.DOUT, 4'b0000);
        chk("reset_edge_a", bus_a.EDGE, 4'b0000);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Clean press on channel 0
        bus_a.RAW = 4'b0001;
        step(6);
        chk("clean_dout0", {3'b0, bus_a.DOUT[0]}, 4'b0001);
        chk("clean_rise0", {3'b0, bus_a.RISE[0]}, 4'b0001);
        step(1);
        chk("clean_rise0_off", {3'b0, bus_a.RISE[0]}, 4'b0000);
        chk("clean_edge0", {3'b0, bus_a.EDGE[0]}, 4'b0001);

        // Bouncing channel 1: toggles every 2 cycles, then holds 1
        rise1_count = 0;
        for (int t = 0; t < 4; t++) begin
            bus_a.RAW[1] = (t % 2 == 0);
            step(2);
        end
        bus_a.RAW[1] = 1'b1;
        step(5);
        chk("bounce_dout1_early", {3'b0, bus_a.DOUT[1]}, 4'b0000);
        step(1);
        chk("bounce_dout1", {3'b0, bus_a.DOUT[1]}, 4'b0001);
        step(3);
        chk("bounce_rise1_count", 4'(rise1_count), 4'd1);

        // Channel 2: clear coinciding with a new RISE leaves EDGE set
        bus_a.RAW[2] = 1'b1;
        step(7);
        chk("ch2_edge_set", {3'b0, bus_a.EDGE[2]}, 4'b0001);
        bus_a.RAW[2] = 1'b0;
        step(7);
        bus_a.RAW[2] = 1'b1;
        step(6);
        chk("ch2_rise", {3'b0, bus_a.RISE[2]}, 4'b0001);
        bus_a.CLR = 4'b0100;
        step(1);
        bus_a.CLR = 4'b0000;
        chk("ch2_set_wins", {3'b0, bus_a.EDGE[2]}, 4'b0001);
        step(2);
        bus_a.CLR = 4'b0100;
        step(1);
        bus_a.CLR = 4'b0000;
        chk("ch2_cleared", {3'b0, bus_a.EDGE[2]}, 4'b0000);

        // Release on channel 0: FALL pulse, EDGE untouched
        bus_a.RAW[0] = 1'b0;
        step(6);
        chk("fall0_pulse", {3'b0, bus_a.FALL[0]}, 4'b0001);
        chk("fall0_edge", {3'b0, bus_a.EDGE[0]}, 4'b0001);
        step(1);
        chk("fall0_off", {3'b0, bus_a.FALL[0]}, 4'b0000);

        // Reset in the middle of qualification
        bus_a.RAW = 4'b0000;
        step(8);
        bus_a.RAW = 4'b1111;
        step(3);
        rst_a = 1'b1;
        model_reset(0);
        #1;
        chk("midq_rst_dout", bus_a.DOUT, 4'b0000);
        chk("midq_rst_edge", bus_a.EDGE, 4'b0000);
        step(2);
        chk("midq_rst_rise", bus_a.RISE, 4'b0000);
        rst_a = 1'b0;
        step(5);
        chk("midq_dout_early", bus_a.DOUT, 4'b0000);
        step(1);
        chk("midq_dout", bus_a.DOUT, 4'b1111);
        chk("midq_rise", bus_a.RISE, 4'b1111);

        // Active-low instance: released keys stay quiet, pressed key 3 accepted
        chk("al_quiet_dout", bus_b.DOUT, 4'b0000);
        bus_b.RAW = 4'b0111;
        step(5);
        chk("al_dout_early", bus_b.DOUT, 4'b0000);
        step(1);
        chk("al_dout3", bus_b.DOUT, 4'b1000);
        chk("al_rise3", bus_b.RISE, 4'b1000);

        // Randomized activity with slow-ish toggling, random clears and rare resets
        for (int r = 0; r < 600; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) bus_a.RAW[c] = ~bus_a.RAW[c];
                if ($urandom_range(0, 5) == 0) bus_b.RAW[c] = ~bus_b.RAW[c];
            end
            bus_a.CLR = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            bus_b.CLR = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) == 0) begin
                rst_a = 1'b1;
                model_reset(0);
            end else if (rst_a) begin
                rst_a = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_b = 1'b1;
                model_reset(1);
            end else if (rst_b) begin
                rst_b = 1'b0;
            end
            #1;
            check_all();
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
